mem_arbiter_rr: RTL

Parametrised N-port arbiter between cache clients (I-cache, D-cache, and further ports such as a prefetcher or L2 victim path) and the single cacheline adapter. Each physical-memory transaction is granted to exactly one port and locked until the adapter responds. The response is returned to that port through a registered one-cycle pulse. Replaces the two-port, unlocked instruction/data arbiter and adds grant locking, a defined idle/busy/done handshake, and selectable fairness.

---
 rtl/mem_arbiter_rr.sv | 90 +++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: locked N-port cacheline arbiter; define ARB_ROUND_ROBIN_EN for round robin, else fixed priority
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             mem_read,
  input  logic [NUM_PORTS-1:0]             mem_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  mem_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  mem_wdata,
  output logic [NUM_PORTS-1:0]             mem_resp,
  output logic [LINE_WIDTH-1:0]            mem_rdata,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_resp
);
  localparam int GW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                 state_q;
  logic [GW-1:0]          g_q, win;
  logic [NUM_PORTS-1:0]   req, g_oh, mem_resp_q;
  logic [LINE_WIDTH-1:0]  mem_rdata_q;
  logic                   busy, sel_rd, sel_wr;
`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0]          ptr_q;
`endif
  assign req  = mem_read | mem_write;
  assign busy = state_q == BUSY;
  assign g_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << g_q;
  // lowest requester wins; round robin then prefers the lowest requester above the pointer
  always_comb begin
    win = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) if (req[i]) win = GW'(i);
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = NUM_PORTS-1; i >= 0; i--) if (req[i] && GW'(i) > ptr_q) win = GW'(i);
`endif
  end
  always_comb begin
    sel_rd       = 1'b0;
    sel_wr       = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (busy && g_q == GW'(i)) begin
        sel_rd       = mem_read[i];
        sel_wr       = mem_write[i];
        pmem_address = mem_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        pmem_wdata   = mem_wdata[i*LINE_WIDTH +: LINE_WIDTH];
      end
  end
  assign pmem_write = sel_wr;
  assign pmem_read  = sel_rd & ~sel_wr;
  assign grant      = busy ? g_oh : '0;
  assign mem_resp   = mem_resp_q;
  assign mem_rdata  = mem_rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= '0;
      mem_resp_q  <= '0;
      mem_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= GW'(NUM_PORTS-1);
`endif
    end else begin
      mem_resp_q <= '0;
      case (state_q)
        IDLE: if (|req) begin
          g_q     <= win;
          state_q <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_q   <= win;
`endif
        end
        BUSY: if (pmem_resp) begin
          mem_rdata_q <= pmem_rdata;
          mem_resp_q  <= g_oh;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
